btn_debounce: RTL and testbench
===============================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE, default 4: consecutive mismatching strobes required to accept a level change (legal range 1..255).
REQ-002 SHALL have parameter LONG_CNT, default 64: strobes held high before a long-press pulse (legal range 1..65535; used only with LONG_PRESS_EN).
REQ-003 SHALL have port i_clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port i_btn, input, 1: raw asynchronous button/pad level, active-high, idle low.
REQ-006 SHALL have port i_stb, input, 1: one-clock sample strobe from clk_div; sampling occurs only on cycles with i_stb high.
REQ-007 SHALL have port o_btn, output, 1: debounced level.
REQ-008 SHALL have port o_press, output, 1: one-clock pulse on accepted rising transition.
REQ-009 SHALL have port o_release, output, 1: one-clock pulse on accepted falling transition.
REQ-010 SHALL have port o_long, output, 1: one-clock long-press pulse (LONG_PRESS_EN only).

Function
REQ-011 SHALL pass i_btn through a two-flop synchronizer every clock, regardless of i_stb; only the second flop output (sync) feeds downstream logic.
REQ-012 SHALL implement states LO, LO_CHK, HI, HI_CHK; o_btn is 0 in LO/LO_CHK, 1 in HI/HI_CHK.
REQ-013 SHALL, in LO on a strobe with sync=1, set count to 1 and enter LO_CHK, or HI directly when DEBOUNCE=1.
REQ-014 SHALL, in LO_CHK on a strobe with sync=1, increment count; when the incremented count equals DEBOUNCE, enter HI and clear count.
REQ-015 SHALL, in LO_CHK on a strobe with sync=0, clear count and return to LO (glitch rejected, no pulse).
REQ-016 SHALL mirror REQ-013..015 for HI/HI_CHK with sync=0 as the mismatching level.
REQ-017 SHALL hold state and count on cycles with i_stb low.
REQ-018 SHALL assert o_press for exactly the one clock following the edge where the state becomes HI from LO/LO_CHK; o_release likewise on entry to LO from HI/HI_CHK; never both in one cycle.
REQ-019 SHALL make o_btn, o_press, o_release registered outputs; latency from stable i_btn change to o_btn change = 2 clocks sync + DEBOUNCE strobes + 1 clock.
REQ-020 SHALL size count as $clog2(DEBOUNCE+1) bits; count never exceeds DEBOUNCE.

Reset
REQ-021 SHALL, on an i_clk edge with i_rst_n=0, force state LO, count 0, synchronizer flops 0, o_btn/o_press/o_release/o_long 0, long counter 0.
REQ-022 SHALL, on reset mid-debounce or mid-press, abandon the operation with no pulse emitted; a button held high through reset is re-accepted per REQ-019 after release of reset.

Configuration
REQ-023 SHALL, with macro BTN_DEBOUNCE_LONG_PRESS_EN defined, count strobes while in HI/HI_CHK, pulse o_long one clock when the count reaches LONG_CNT, saturate (one pulse per press), and clear the count on entry to LO.
REQ-024 SHALL, without BTN_DEBOUNCE_LONG_PRESS_EN, tie o_long to constant 0 and omit the long counter; all other behaviour identical.
REQ-025 SHALL size the long counter as $clog2(LONG_CNT+1) bits.

Structure
REQ-026 SHALL place the state encodings (LO=2'b00, LO_CHK=2'b01, HI=2'b10, HI_CHK=2'b11) in the shared header btn_debounce_defs.vh, included by RTL and bench.
REQ-027 SHALL instantiate one sub-module, sync2 (two-flop synchronizer, reset to 0); strobe generation stays external (clk_div).

Verification
REQ-028 Bench SHALL cover: i_stb every 4 clocks, DEBOUNCE=4, i_btn 0->1 held -> o_btn=1 and single o_press exactly 2+16+1 clocks (±strobe phase) later.
REQ-029 Bench SHALL cover: i_btn high for 3 strobes then low -> o_btn stays 0, no o_press.
REQ-030 Bench SHALL cover: accepted press, then i_btn low 4 strobes -> single o_release, o_btn=0.
REQ-031 Bench SHALL cover: i_rst_n=0 for 1 clock while in HI_CHK -> all outputs 0 next cycle, no o_release.
REQ-032 Bench SHALL cover: LONG_PRESS_EN, LONG_CNT=8, hold 20 strobes -> one o_long after 8th held strobe; without macro o_long stays 0.
REQ-033 Bench SHALL cover: DEBOUNCE=1, i_stb tied 1 -> o_btn follows sync with 1 clock delay, one pulse per edge.

Source files
------------

// File: rtl/btn_debounce_pkg.sv
// Types shared by the btn_debounce block. Bit 1 of a state is the debounced level,
// bit 0 marks a pending (unconfirmed) level change.
`include "btn_debounce_defs.vh"

package btn_debounce_pkg;

    typedef enum logic [1:0] {
        StLo    = `BTN_DEBOUNCE_ST_LO,
        StLoChk = `BTN_DEBOUNCE_ST_LO_CHK,
        StHi    = `BTN_DEBOUNCE_ST_HI,
        StHiChk = `BTN_DEBOUNCE_ST_HI_CHK
    } state_e;

endpackage

// File: rtl/btn_debounce_defs.vh
// Shared state encodings for btn_debounce, used by the RTL package and the bench.
`ifndef BTN_DEBOUNCE_DEFS_VH
`define BTN_DEBOUNCE_DEFS_VH

`define BTN_DEBOUNCE_ST_LO     2'b00
`define BTN_DEBOUNCE_ST_LO_CHK 2'b01
`define BTN_DEBOUNCE_ST_HI     2'b10
`define BTN_DEBOUNCE_ST_HI_CHK 2'b11

`endif

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous level; both flops clear on synchronous reset.
module sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic s1_q, s2_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/btn_debounce.sv
// Strobe-sampled button debouncer with registered level and press/release pulses.
// Optional long-press pulse is built only when BTN_DEBOUNCE_LONG_PRESS_EN is defined.
module btn_debounce #(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned LONG_CNT = 64
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    input  logic i_stb,
    output logic o_btn,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    import btn_debounce_pkg::*;

    localparam int unsigned CntW = $clog2(DEBOUNCE + 1);
    localparam logic [CntW-1:0] DebMax = CntW'(DEBOUNCE);

    if (DEBOUNCE < 1 || DEBOUNCE > 255) begin : g_bad_debounce
        $error("btn_debounce: DEBOUNCE must be 1..255");
    end
    if (LONG_CNT < 1 || LONG_CNT > 65535) begin : g_bad_long_cnt
        $error("btn_debounce: LONG_CNT must be 1..65535");
    end

    logic            sync;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic            press_q, release_q;

    sync2 u_sync2 (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .d_i    (i_btn),
        .q_o    (sync)
    );

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (i_stb) begin
            unique case (state_q)
                StLo: begin
                    if (sync) begin
                        if (DEBOUNCE == 1) begin
                            state_d = StHi;
                        end else begin
                            state_d = StLoChk;
                            cnt_d   = CntW'(1);
                        end
                    end
                end
                StLoChk: begin
                    if (!sync) begin
                        state_d = StLo;
                        cnt_d   = '0;
                    end else if (cnt_inc == DebMax) begin
                        state_d = StHi;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StHi: begin
                    if (!sync) begin
                        if (DEBOUNCE == 1) begin
                            state_d = StLo;
                        end else begin
                            state_d = StHiChk;
                            cnt_d   = CntW'(1);
                        end
                    end
                end
                StHiChk: begin
                    if (sync) begin
                        state_d = StHi;
                        cnt_d   = '0;
                    end else if (cnt_inc == DebMax) begin
                        state_d = StLo;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = StLo;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Pulses fire on a change of the level bit only, so glitch rejection is silent.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= StLo;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= !state_q[1] && state_d[1];
            release_q <= state_q[1] && !state_d[1];
        end
    end

    assign o_btn     = state_q[1];
    assign o_press   = press_q;
    assign o_release = release_q;

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned LongW = $clog2(LONG_CNT + 1);
    localparam logic [LongW-1:0] LongMax = LongW'(LONG_CNT);

    logic [LongW-1:0] long_cnt_q, long_cnt_d;
    logic             long_q, long_d;

    // Saturating at LongMax gives exactly one pulse per press.
    always_comb begin
        long_cnt_d = long_cnt_q;
        long_d     = 1'b0;
        if (!state_d[1]) begin
            long_cnt_d = '0;
        end else if (i_stb && state_q[1] && long_cnt_q != LongMax) begin
            long_cnt_d = long_cnt_q + 1'b1;
            long_d     = (long_cnt_d == LongMax);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            long_cnt_q <= '0;
            long_q     <= 1'b0;
        end else begin
            long_cnt_q <= long_cnt_d;
            long_q     <= long_d;
        end
    end

    assign o_long = long_q;
`else
    assign o_long = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: DEBOUNCE=1 table with a latency scoreboard, plus DEBOUNCE=4
// strobed sequences for press, glitch, release, mid-debounce reset and long press.
`ifndef BTN_DEBOUNCE_DEFS_VH
`include "btn_debounce_defs.vh"
`endif

module tb_btn_debounce;

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    localparam bit LongEn = 1'b1;
`else
    localparam bit LongEn = 1'b0;
`endif

    typedef struct packed {
        logic       btn;
        logic [2:0] exp;  // {o_btn, o_press, o_release}
    } vec_t;

    logic clk, rst_n;
    logic btn1, btn4, stb4;
    logic o_btn1, o_press1, o_release1, o_long1;
    logic o_btn4, o_press4, o_release4, o_long4;

    int n_checks = 0;
    int n_errors = 0;
    int ph = 0;
    int press_cnt = 0, rel_cnt = 0, long_cnt = 0, both_cnt = 0;

    logic [2:0] exp_q[$];
    vec_t       vecs[14];

    btn_debounce #(.DEBOUNCE(1)) dut1 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_btn     (btn1),
        .i_stb     (1'b1),
        .o_btn     (o_btn1),
        .o_press   (o_press1),
        .o_release (o_release1),
        .o_long    (o_long1)
    );

    btn_debounce #(.DEBOUNCE(4), .LONG_CNT(8)) dut4 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_btn     (btn4),
        .i_stb     (stb4),
        .o_btn     (o_btn4),
        .o_press   (o_press4),
        .o_release (o_release4),
        .o_long    (o_long4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-clock strobe every 4 clocks.
    initial begin
        stb4 = 1'b0;
        forever begin
            @(negedge clk);
            stb4 = (ph == 3);
            ph = (ph + 1) % 4;
        end
    end

    always @(negedge clk) begin
        if (o_press4) press_cnt <= press_cnt + 1;
        if (o_release4) rel_cnt <= rel_cnt + 1;
        if (o_long4) long_cnt <= long_cnt + 1;
        if ((o_press4 && o_release4) || (o_press1 && o_release1)) both_cnt <= both_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns at the falling edge just after a strobe was sampled by the DUT.
    task automatic wait_after_strobe();
        do @(posedge clk); while (stb4 !== 1'b1);
        @(negedge clk);
    endtask

    task automatic wait_press(output int lat, output bit seen);
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (o_press4) begin
                seen = 1'b1;
                lat  = k;
            end
        end
    endtask

    initial begin
        int  lat, p0, r0, l0;
        bit  seen;
        logic [2:0] e;

        vecs[0]  = '{btn: 1'b0, exp: 3'b000};
        vecs[1]  = '{btn: 1'b1, exp: 3'b110};
        vecs[2]  = '{btn: 1'b1, exp: 3'b100};
        vecs[3]  = '{btn: 1'b0, exp: 3'b001};
        vecs[4]  = '{btn: 1'b1, exp: 3'b110};
        vecs[5]  = '{btn: 1'b0, exp: 3'b001};
        vecs[6]  = '{btn: 1'b0, exp: 3'b000};
        vecs[7]  = '{btn: 1'b1, exp: 3'b110};
        vecs[8]  = '{btn: 1'b1, exp: 3'b100};
        vecs[9]  = '{btn: 1'b1, exp: 3'b100};
        vecs[10] = '{btn: 1'b0, exp: 3'b001};
        vecs[11] = '{btn: 1'b1, exp: 3'b110};
        vecs[12] = '{btn: 1'b0, exp: 3'b001};
        vecs[13] = '{btn: 1'b0, exp: 3'b000};

        rst_n = 1'b0;
        btn1  = 1'b0;
        btn4  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out_d4", 32'({o_btn4, o_press4, o_release4, o_long4}), 32'd0);
        check("reset_out_d1", 32'({o_btn1, o_press1, o_release1, o_long1}), 32'd0);
        rst_n = 1'b1;

        // DEBOUNCE=1, strobe tied high: outputs lag the input by 3 clocks.
        repeat (3) exp_q.push_back(3'b000);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("d1_vec%0d", i), 32'({o_btn1, o_press1, o_release1}), 32'(e));
            btn1 = vecs[i].btn;
            exp_q.push_back(vecs[i].exp);
        end
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check("d1_drain", 32'({o_btn1, o_press1, o_release1}), 32'(e));
        end

        // Press: 2 sync clocks + 4 strobes + output register, less strobe phase.
        repeat (4) @(negedge clk);
        wait_after_strobe();
        p0   = press_cnt;
        btn4 = 1'b1;
        wait_press(lat, seen);
        check("press_seen", 32'(seen), 32'd1);
        check("press_latency_window", 32'(lat >= 15 && lat <= 19), 32'd1);
        repeat (20) @(negedge clk);
        check("press_level", 32'(o_btn4), 32'd1);
        check("press_single", 32'(press_cnt - p0), 32'd1);

        // Release after 4 low strobes.
        wait_after_strobe();
        p0   = press_cnt;
        r0   = rel_cnt;
        btn4 = 1'b0;
        repeat (4) wait_after_strobe();
        check("release_pulse", 32'(o_release4), 32'd1);
        repeat (10) @(negedge clk);
        check("release_level", 32'(o_btn4), 32'd0);
        check("release_single", 32'(rel_cnt - r0), 32'd1);
        check("release_no_press", 32'(press_cnt - p0), 32'd0);

        // Glitch: high for only 3 strobes.
        wait_after_strobe();
        p0   = press_cnt;
        btn4 = 1'b1;
        repeat (3) wait_after_strobe();
        btn4 = 1'b0;
        repeat (30) @(negedge clk);
        check("glitch_level", 32'(o_btn4), 32'd0);
        check("glitch_no_press", 32'(press_cnt - p0), 32'd0);

        // Reset while a release is being debounced.
        wait_after_strobe();
        btn4 = 1'b1;
        repeat (4) wait_after_strobe();
        check("hichk_accepted", 32'(o_btn4), 32'd1);
        btn4 = 1'b0;
        repeat (2) wait_after_strobe();
        check("hichk_level_held", 32'(o_btn4), 32'd1);
        r0    = rel_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        check("hichk_reset_out", 32'({o_btn4, o_press4, o_release4, o_long4}), 32'd0);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("hichk_no_release", 32'(rel_cnt - r0), 32'd0);

        // Long press: pulse after the 8th strobe held in the high state.
        wait_after_strobe();
        l0   = long_cnt;
        btn4 = 1'b1;
        repeat (4) wait_after_strobe();
        check("long_press_accept", 32'(o_press4), 32'd1);
        for (int k = 1; k <= 20; k++) begin
            wait_after_strobe();
            check($sformatf("long_strobe%0d", k), 32'(o_long4), 32'(LongEn && k == 8));
        end
        btn4 = 1'b0;
        repeat (4) wait_after_strobe();
        repeat (4) @(negedge clk);
        check("long_count", 32'(long_cnt - l0), 32'(LongEn ? 1 : 0));
        check("long_released", 32'(o_btn4), 32'd0);
        check("never_both_pulses", 32'(both_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
